drop_sequencer: RTL and testbench
=================================

// Module: drop_sequencer
// PURPOSE
//  Sequential stage directly downstream of sensors_input; consumes its averaged 8-bit height.
//  On a drop request, the block:
//   - waits until the height is stable;
//   - checks free-fall physics h <= (G_HALF*t^2)>>T_FRAC against the elapsed-time input;
//   - pulses the drop actuator enable, then enforces a cooldown.
//  Drives a 2-bit status code consumed by the display logic.
// PARAMETERS
//  STABLE_CYC  8   consecutive cycles height must stay unchanged before evaluation
//  G_HALF      5   g/2 constant, integer, 4 bits
//  T_FRAC      4   fractional bits of t_act (t_act = seconds * 2^T_FRAC)
//  DROP_CYC    4   cycles drop_en stays high per drop
//  HOLD_CYC    16  cooldown cycles after a drop or abort-from-DROP
// PORTS
//  clk       in   1  single clock, all logic rising-edge
//  rst       in   1  synchronous, active-high reset
//  height    in   8  averaged height from sensors_input; 0 = invalid/no reading
//  t_act     in   8  elapsed time, unsigned fixed point, T_FRAC fraction bits
//  drop_req  in   1  request pulse; sampled only in IDLE
//  abort     in   1  cancel; priority over everything except rst
//  drop_en   out  1  actuator enable, registered
//  busy      out  1  high in every state except IDLE
//  status    out  2  00 IDLE, 01 COLD (too early), 10 DROP, 11 HOLD/ERR
//  h_cap     out  8  height latched for the current sequence
// BEHAVIOUR
//  Reset: state=IDLE; drop_en=0, busy=0, status=00, h_cap=0, counters=0.
//   Reset mid-sequence forces drop_en=0 at that same edge.
//  All outputs are registered and change only on the rising edge of clk.
//  IDLE:
//   - drop_req=1 && height!=0 -> SETTLE; h_cap<=height, cnt<=0.
//   - drop_req with height==0 -> stay IDLE.
//  SETTLE:
//   - height==0 -> HOLD, status=11 (ERR).
//   - height!=h_cap -> h_cap<=height, cnt<=0.
//   - Otherwise cnt++; at cnt==STABLE_CYC-1 -> EVAL.
//   - Exactly STABLE_CYC equal samples are needed after the last change.
//  EVAL: one cycle; registers h_fall=(G_HALF*t_act*t_act)>>T_FRAC.
//   - Product is 20 bits unsigned, no truncation before the shift.
//  CMP:
//   - h_fall >= h_cap -> DROP.
//   - Else -> COLD.
//   - Request-to-drop_en latency = STABLE_CYC+2 cycles.
//  COLD: status=01; recompute h_fall from live t_act every cycle (2-cycle pipeline).
//   - Enter DROP on the first cycle the compare passes.
//   - t_act wrap from 255 to 0 does not cause a drop.
//  DROP: drop_en=1, status=10 for exactly DROP_CYC cycles, then HOLD.
//  HOLD: status=11, drop_en=0 for HOLD_CYC cycles, then IDLE.
//  drop_req outside IDLE is ignored, with no queuing.
//  abort:
//   - In SETTLE/EVAL/CMP/COLD -> IDLE next edge.
//   - In DROP -> HOLD next edge; drop_en=0 at that edge, so no partial pulse is extended.
//   - abort and drop_req in the same cycle in IDLE -> stay IDLE.
//  Counters saturate and never wrap; parameter values of 0 are illegal (elaboration check).
// STRUCTURE
//  Package drop_pkg holds:
//   - state encoding (IDLE, SETTLE, EVAL, CMP, COLD, DROP, HOLD; 3 bits);
//   - status codes ST_IDLE/ST_COLD/ST_DROP/ST_HOLD;
//   - width constants H_W=8, T_W=8, HF_W=20.
//  Sub-module fall_height_calc: registered multiply-shift t_act -> h_fall, 1-cycle latency.
//  The FSM and counters live in the top module.
// TESTING (defaults G_HALF=5, T_FRAC=4, STABLE_CYC=8)
//  1. height=80, t_act=16 (h_fall=80), drop_req pulse:
//     drop_en rises 10 cycles later, high 4 cycles; HOLD 16 cycles; then IDLE.
//  2. height=100, t_act=16: status=01 (COLD).
//     Ramp t_act to 18 (h_fall=101): drop_en rises 2 cycles after t_act=18.
//  3. height toggles 60/61 during SETTLE every 5 cycles: never leaves SETTLE.
//     Hold at 61: EVAL after 8 stable cycles, h_cap=61.
//  4. height=0 at drop_req: stays IDLE. height drops to 0 mid-SETTLE: HOLD with status=11.
//  5. abort on 2nd DROP cycle: drop_en low next edge, HOLD 16 cycles.
//     drop_req during HOLD is ignored.
//  6. rst asserted in COLD and in DROP: all outputs reset values next edge.
//     drop_req in the cycle after rst is released starts a new sequence.

Source files
------------

// File: rtl/drop_pkg.sv
// drop_pkg: shared types and constants for the drop sequencer.
// Holds state encoding, status codes, datapath widths and a small helper.
package drop_pkg;

    localparam int H_W  = 8;
    localparam int T_W  = 8;
    localparam int HF_W = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_EVAL,
        S_CMP,
        S_COLD,
        S_DROP,
        S_HOLD
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_COLD = 2'b01;
    localparam logic [1:0] ST_DROP = 2'b10;
    localparam logic [1:0] ST_HOLD = 2'b11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Settling and evaluation report as idle; busy tells them apart.
    function automatic logic [1:0] status_of(input state_e s);
        logic [1:0] st;
        case (s)
            S_COLD:  st = ST_COLD;
            S_DROP:  st = ST_DROP;
            S_HOLD:  st = ST_HOLD;
            default: st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/fall_height_calc.sv
// fall_height_calc: registered free-fall height h = (G_HALF*t^2) >> T_FRAC.
// Ports: clk, rst in; t_act in (fixed point); h_fall out, one cycle after t_act.
module fall_height_calc
    import drop_pkg::*;
#(
    parameter int G_HALF = 5,
    parameter int T_FRAC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [T_W-1:0]  t_act,
    output logic [HF_W-1:0] h_fall
);

    logic [HF_W-1:0] prod;
    logic [HF_W-1:0] h_fall_d;
    logic [HF_W-1:0] h_fall_q;

    // Full 20-bit product is formed before the shift drops the fraction.
    always_comb begin
        prod     = HF_W'(G_HALF) * HF_W'(t_act) * HF_W'(t_act);
        h_fall_d = prod >> T_FRAC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_fall_q <= '0;
        end else begin
            h_fall_q <= h_fall_d;
        end
    end

    assign h_fall = h_fall_q;

endmodule

// File: rtl/drop_sequencer.sv
// drop_sequencer: waits for a stable height, checks free-fall time, pulses drop.
// Ports: clk, rst, height, t_act, drop_req, abort in; drop_en, busy, status, h_cap out.
module drop_sequencer
    import drop_pkg::*;
#(
    parameter int STABLE_CYC = 8,
    parameter int G_HALF     = 5,
    parameter int T_FRAC     = 4,
    parameter int DROP_CYC   = 4,
    parameter int HOLD_CYC   = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [H_W-1:0] height,
    input  logic [T_W-1:0] t_act,
    input  logic           drop_req,
    input  logic           abort,
    output logic           drop_en,
    output logic           busy,
    output logic [1:0]     status,
    output logic [H_W-1:0] h_cap
);

    localparam int MAX_CYC = max3(STABLE_CYC, DROP_CYC, HOLD_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] DROP_LAST   = CNT_W'(DROP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    if (STABLE_CYC < 1 || DROP_CYC < 1 || HOLD_CYC < 1 ||
        T_FRAC < 1 || G_HALF < 1 || G_HALF > 15) begin : g_bad_param
        $error("drop_sequencer: illegal parameter value");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [H_W-1:0]   h_cap_q, h_cap_d;
    logic             drop_en_q, drop_en_d;
    logic             busy_q, busy_d;
    logic [1:0]       status_q, status_d;
    logic [HF_W-1:0]  h_fall;
    logic             fall_ok;

    fall_height_calc #(
        .G_HALF (G_HALF),
        .T_FRAC (T_FRAC)
    ) u_fall (
        .clk    (clk),
        .rst    (rst),
        .t_act  (t_act),
        .h_fall (h_fall)
    );

    // Saturating increment keeps a stuck sequence from wrapping back.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign fall_ok = h_fall >= HF_W'(h_cap_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_cap_d = h_cap_q;
        unique case (state_q)
            S_IDLE: begin
                if (!abort && drop_req && height != '0) begin
                    state_d = S_SETTLE;
                    h_cap_d = height;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (height == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (height != h_cap_q) begin
                    h_cap_d = height;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_EVAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_EVAL: begin
                state_d = abort ? S_IDLE : S_CMP;
            end
            // COLD keeps comparing against the live h_fall pipeline.
            S_CMP, S_COLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (fall_ok) begin
                    state_d = S_DROP;
                    cnt_d   = '0;
                end else begin
                    state_d = S_COLD;
                end
            end
            S_DROP: begin
                if (abort || cnt_q == DROP_LAST) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            // The cooldown is not shortened by abort.
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        drop_en_d = (state_d == S_DROP);
        busy_d    = (state_d != S_IDLE);
        status_d  = status_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            h_cap_q   <= '0;
            drop_en_q <= 1'b0;
            busy_q    <= 1'b0;
            status_q  <= ST_IDLE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            h_cap_q   <= h_cap_d;
            drop_en_q <= drop_en_d;
            busy_q    <= busy_d;
            status_q  <= status_d;
        end
    end

    assign drop_en = drop_en_q;
    assign busy    = busy_q;
    assign status  = status_q;
    assign h_cap   = h_cap_q;

endmodule

// File: tb/tb_drop_sequencer.sv
// tb_drop_sequencer: directed scenarios plus random stimulus vs. a behavioural model.
// Ports: none; drives drop_sequencer and reports one summary line.
module tb_drop_sequencer;

    localparam int G_HALF = 5;
    localparam int T_FRAC = 4;
    localparam int N_STB  = 8;
    localparam int N_DROP = 4;
    localparam int N_HOLD = 16;

    localparam int P_IDLE   = 0;
    localparam int P_SETTLE = 1;
    localparam int P_EVAL   = 2;
    localparam int P_CMP    = 3;
    localparam int P_COLD   = 4;
    localparam int P_DROP   = 5;
    localparam int P_HOLD   = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] height;
    logic [7:0] t_act;
    logic       drop_req;
    logic       abort;
    logic       drop_en;
    logic       busy;
    logic [1:0] status;
    logic [7:0] h_cap;

    int checks = 0;
    int errors = 0;

    int m_ph  = P_IDLE;
    int m_cap = 0;
    int m_n   = 0;
    int m_hf  = 0;

    drop_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .height   (height),
        .t_act    (t_act),
        .drop_req (drop_req),
        .abort    (abort),
        .drop_en  (drop_en),
        .busy     (busy),
        .status   (status),
        .h_cap    (h_cap)
    );

    always #5 clk = ~clk;

    function automatic int fall_of(input int t);
        return (G_HALF * t * t) >> T_FRAC;
    endfunction

    // Reference: m_hf is the fall height seen by the compare this cycle,
    // computed from the time value sampled one edge earlier.
    always @(posedge clk) begin : model
        int hf_seen;
        hf_seen = m_hf;
        m_hf = rst ? 0 : fall_of(int'(t_act));
        if (rst) begin
            m_ph  = P_IDLE;
            m_cap = 0;
            m_n   = 0;
        end else begin
            case (m_ph)
                P_IDLE: begin
                    if (!abort && drop_req && height != 0) begin
                        m_ph  = P_SETTLE;
                        m_cap = int'(height);
                        m_n   = 0;
                    end
                end
                P_SETTLE: begin
                    if (abort) m_ph = P_IDLE;
                    else if (height == 0) begin
                        m_ph = P_HOLD;
                        m_n  = 0;
                    end else if (int'(height) != m_cap) begin
                        m_cap = int'(height);
                        m_n   = 0;
                    end else begin
                        m_n++;
                        if (m_n == N_STB) m_ph = P_EVAL;
                    end
                end
                P_EVAL: m_ph = abort ? P_IDLE : P_CMP;
                P_CMP, P_COLD: begin
                    if (abort) m_ph = P_IDLE;
                    else if (hf_seen >= m_cap) begin
                        m_ph = P_DROP;
                        m_n  = 0;
                    end else m_ph = P_COLD;
                end
                P_DROP: begin
                    m_n++;
                    if (abort || m_n == N_DROP) begin
                        m_ph = P_HOLD;
                        m_n  = 0;
                    end
                end
                default: begin
                    m_n++;
                    if (m_n == N_HOLD) m_ph = P_IDLE;
                end
            endcase
        end
    end

    always @(negedge clk) begin : compare
        int e_en, e_busy, e_st;
        e_en   = (m_ph == P_DROP) ? 1 : 0;
        e_busy = (m_ph != P_IDLE) ? 1 : 0;
        case (m_ph)
            P_COLD:  e_st = 1;
            P_DROP:  e_st = 2;
            P_HOLD:  e_st = 3;
            default: e_st = 0;
        endcase
        checks++;
        if (int'(drop_en) != e_en || int'(busy) != e_busy ||
            int'(status) != e_st || int'(h_cap) != m_cap) begin
            errors++;
            $display("FAIL model_cmp @%0t: dut en=%0d busy=%0d st=%0d cap=%0d, model en=%0d busy=%0d st=%0d cap=%0d",
                     $time, drop_en, busy, status, h_cap,
                     e_en, e_busy, e_st, m_cap);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_req(input logic [7:0] h);
        height   = h;
        drop_req = 1'b1;
        @(negedge clk);
        drop_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(busy), 0);
        @(negedge clk);
    endtask

    task automatic wait_drop(output int lat);
        lat = 0;
        while (!drop_en && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    logic [7:0] hsel [6] = '{8'd0, 8'd20, 8'd50, 8'd80, 8'd120, 8'd200};

    initial begin
        int lat, hi, ho;
        rst      = 1'b1;
        height   = 8'd0;
        t_act    = 8'd0;
        drop_req = 1'b0;
        abort    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_drop_en", int'(drop_en), 0);
        check("rst_status", int'(status), 0);
        check("rst_h_cap", int'(h_cap), 0);
        rst = 1'b0;
        check("model_fall_16", fall_of(16), 80);
        check("model_fall_18", fall_of(18), 101);
        check("model_fall_255", fall_of(255), 20320);

        // 1: basic drop timing
        t_act = 8'd16;
        pulse_req(8'd80);
        wait_drop(lat);
        check("t1_latency", lat, 10);
        check("t1_status_drop", int'(status), 2);
        check("t1_h_cap", int'(h_cap), 80);
        hi = 0;
        while (drop_en && hi < 40) begin
            @(negedge clk);
            hi++;
        end
        check("t1_drop_len", hi, 4);
        check("t1_status_hold", int'(status), 3);
        ho = 0;
        while (busy && ho < 60) begin
            @(negedge clk);
            ho++;
        end
        check("t1_hold_len", ho, 16);
        check("t1_status_idle", int'(status), 0);

        // 2: too early, then time ramps up
        t_act = 8'd16;
        pulse_req(8'd100);
        lat = 0;
        while (status != 2'b01 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("t2_cold", int'(status), 1);
        check("t2_h_cap", int'(h_cap), 100);
        t_act = 8'd17;
        repeat (3) @(negedge clk);
        check("t2_still_cold", int'(status), 1);
        t_act = 8'd18;
        wait_drop(lat);
        check("t2_ramp_latency", lat, 2);
        wait_idle("t2_idle");

        // 3: height toggling keeps it settling
        t_act = 8'd32;
        pulse_req(8'd60);
        for (int k = 0; k < 4; k++) begin
            repeat (5) @(negedge clk);
            height = (height == 8'd60) ? 8'd61 : 8'd60;
        end
        repeat (4) @(negedge clk);
        check("t3_settling_busy", int'(busy), 1);
        check("t3_settling_st", int'(status), 0);
        @(negedge clk);
        height = 8'd61;
        wait_drop(lat);
        check("t3_stable_latency", lat, 11);
        check("t3_h_cap", int'(h_cap), 61);
        wait_idle("t3_idle");

        // 4: invalid height
        pulse_req(8'd0);
        check("t4_no_start", int'(busy), 0);
        pulse_req(8'd50);
        repeat (3) @(negedge clk);
        height = 8'd0;
        @(negedge clk);
        check("t4_err_status", int'(status), 3);
        check("t4_err_busy", int'(busy), 1);
        wait_idle("t4_idle");

        // 5: abort in DROP, request in HOLD ignored
        t_act = 8'd32;
        pulse_req(8'd40);
        wait_drop(lat);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_en", int'(drop_en), 0);
        check("t5_abort_st", int'(status), 3);
        drop_req = 1'b1;
        @(negedge clk);
        drop_req = 1'b0;
        ho = 1;
        while (busy && ho < 60) begin
            @(negedge clk);
            ho++;
        end
        check("t5_hold_len", ho, 16);
        @(negedge clk);
        check("t5_no_queue", int'(busy), 0);

        // 6: reset in COLD and DROP
        t_act = 8'd16;
        pulse_req(8'd100);
        lat = 0;
        while (status != 2'b01 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_cold_rst_busy", int'(busy), 0);
        check("t6_cold_rst_cap", int'(h_cap), 0);
        t_act = 8'd32;
        pulse_req(8'd40);
        wait_drop(lat);
        rst = 1'b1;
        @(negedge clk);
        check("t6_drop_rst_en", int'(drop_en), 0);
        check("t6_drop_rst_st", int'(status), 0);
        rst      = 1'b0;
        height   = 8'd40;
        drop_req = 1'b1;
        @(negedge clk);
        drop_req = 1'b0;
        check("t6_restart_busy", int'(busy), 1);
        check("t6_restart_cap", int'(h_cap), 40);
        wait_idle("t6_idle");

        // random phase, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            abort    = ($urandom_range(0, 39) == 0);
            drop_req = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 11) == 0)
                height = hsel[$urandom_range(0, 5)];
            else if ($urandom_range(0, 29) == 0)
                height = height + 8'd1;
            case ($urandom_range(0, 3))
                0: t_act = t_act + 8'd1;
                1: t_act = t_act - 8'd1;
                2: t_act = t_act;
                default: begin
                    if ($urandom_range(0, 7) == 0)
                        t_act = 8'($urandom_range(0, 255));
                end
            endcase
            @(negedge clk);
        end
        rst      = 1'b0;
        abort    = 1'b0;
        drop_req = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
